// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event controller.
// Optional E0 extended-prefix handling is enabled by defining PS2_EXT_PREFIX_EN.
// Without it, E0 is treated as a byte to ignore and the extended states are not built.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

`ifdef PS2_EXT_PREFIX_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} ps2_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BRK = 2'd2} ps2_state_t;
`endif

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_event_t;

  // Controller/status bytes that never start a key sequence from IDLE.
  function automatic logic ps2_is_ignored(input logic [7:0] b);
    logic ign;
    ign = (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
          (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
`ifndef PS2_EXT_PREFIX_EN
    ign = ign || (b == PS2_EXT);
`endif
    return ign;
  endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / event-out bundle for the PS/2 key event controller.
// The slave modport is the controller; master is the byte source plus event consumer.
// Events use valid/ready; a head event is consumed when ev_valid & ev_ready.
interface ps2_key_event_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;

  modport master (output rx_valid, rx_data, ev_ready,
                  input  ev_valid, ev_code, ev_break, ev_ext);
  modport slave  (input  rx_valid, rx_data, ev_ready,
                  output ev_valid, ev_code, ev_break, ev_ext);
endinterface

// File: rtl/ps2_event_fifo.sv
// Small synchronous event FIFO with extra pointer bit for full/empty.
// Latency: pushed entry visible at head the next cycle.
// Backpressure: push refused when full unless a pop happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  ps2_event_t push_dat,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic       push_ok,
  output ps2_event_t head
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t      mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   last_idx;
  logic            do_pop;

  assign rd_idx   = rd_ptr[AW-1:0];
  assign last_idx = rd_idx - AW'(1);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign push_ok  = push && (!full || do_pop);

  // When empty, show the most recently popped slot so the head holds its last value.
  assign head = empty ? mem[last_idx] : mem[rd_idx];

  // Storage and pointer update; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Scan-code sequencer: turns PS/2 bytes into make/break events, tracks held key, buffers events.
// Latency: event valid the cycle after the final byte of a sequence is strobed in.
// Backpressure: ev_ready stalls the FIFO; events arriving while full are dropped and flag overflow.
// Extended (E0) prefix support is built when PS2_EXT_PREFIX_EN is defined.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  ps2_key_event_ctrl_if.slave  bus,
  output logic                 key_held,
  output logic [7:0]           held_code,
  output logic [7:0]           press_count,
  output logic                 seg_en,
  output logic                 overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);

  ps2_state_t  state, state_n;
  logic [TW-1:0] timer;
  logic        make_cand;
  logic        brk_evt;
  logic        is_ext;
  logic        key_match;
  logic        make_evt;
  logic        ev_push;
  ps2_event_t  ev_dat;
  ps2_event_t  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_ok;

`ifdef PS2_EXT_PREFIX_EN
  logic        held_ext;
  assign key_match = key_held && (bus.rx_data == held_code) && (is_ext == held_ext);
`else
  assign key_match = key_held && (bus.rx_data == held_code);
`endif

  // A make that repeats the held key is typematic and produces nothing.
  assign make_evt    = make_cand && !key_match;
  assign ev_push     = make_evt || brk_evt;
  assign ev_dat.code = bus.rx_data;
  assign ev_dat.brk  = brk_evt;
  assign ev_dat.ext  = is_ext;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode and event classification of the incoming byte.
  always_comb begin
    state_n   = state;
    make_cand = 1'b0;
    brk_evt   = 1'b0;
    is_ext    = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        IDLE: begin
`ifdef PS2_EXT_PREFIX_EN
          if (bus.rx_data == PS2_EXT) state_n = EXT;
          else
`endif
          if (bus.rx_data == PS2_BRK) state_n = BRK;
          else if (!ps2_is_ignored(bus.rx_data)) make_cand = 1'b1;
        end
`ifdef PS2_EXT_PREFIX_EN
        EXT: begin
          if (bus.rx_data == PS2_BRK) state_n = EXT_BRK;
          else if (bus.rx_data == PS2_EXT) state_n = EXT;
          else begin
            make_cand = 1'b1;
            is_ext    = 1'b1;
            state_n   = IDLE;
          end
        end
        EXT_BRK: begin
          brk_evt = 1'b1;
          is_ext  = 1'b1;
          state_n = IDLE;
        end
`endif
        BRK: begin
          brk_evt = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if ((state != IDLE) && (timer == TW'(TIMEOUT - 1))) begin
      state_n = IDLE;
    end
  end

  // Prefix timer: restarts on each byte, runs only while waiting inside a prefix.
  always_ff @(posedge clk) begin
    if (!resetn || bus.rx_valid || (state == IDLE) || (state_n == IDLE)) timer <= '0;
    else                                                                  timer <= timer + 1'b1;
  end

  // Held-key tracking, press counter, display enable and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_held    <= 1'b0;
      held_code   <= 8'h00;
      press_count <= 8'h00;
      seg_en      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (make_evt) begin
        key_held    <= 1'b1;
        seg_en      <= 1'b1;
        held_code   <= bus.rx_data;
        press_count <= press_count + 8'd1;
      end else if (brk_evt && key_match) begin
        key_held  <= 1'b0;
        seg_en    <= 1'b0;
        held_code <= 8'h00;
      end
      if (ev_push && !push_ok) overflow <= 1'b1;
    end
  end

`ifdef PS2_EXT_PREFIX_EN
  // Extended flag of the held key, needed to tell e.g. keypad 75 from arrow E0 75.
  always_ff @(posedge clk) begin
    if (!resetn)                  held_ext <= 1'b0;
    else if (make_evt)            held_ext <= is_ext;
    else if (brk_evt && key_match) held_ext <= 1'b0;
  end
`endif

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (ev_push),
    .push_dat (ev_dat),
    .pop      (bus.ev_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .push_ok  (push_ok),
    .head     (head)
  );

  assign bus.ev_valid = !fifo_empty;
  assign bus.ev_code  = head.code;
  assign bus.ev_break = head.brk;
  assign bus.ev_ext   = head.ext;

endmodule
